// File: rtl/fetch_queue.sv
// fetch_queue: in-order buffer of {pc, instr} pairs between fetch and decode.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high; clears pointers and count
//   flush      discards every entry at the next edge (branch redirect)
//   in_valid   fetch presents {in_pc, in_instr} this cycle
//   in_ready   queue has room; depends on registered state only
//   in_pc      PC of the fetched word
//   in_instr   fetched instruction word
//   out_valid  head entry is available to decode
//   out_ready  decode consumes the head entry this cycle
//   out_pc     PC of the head entry (zero when empty)
//   out_instr  instruction of the head entry (zero when empty)
//   count      number of valid entries, 0..DEPTH
module fetch_queue #(
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned PC_W    = 64,
    parameter int unsigned INSTR_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PC_W-1:0]          in_pc,
    input  logic [INSTR_W-1:0]       in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PC_W-1:0]          out_pc,
    output logic [INSTR_W-1:0]       out_instr,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PC_W-1:0]    mem_pc    [DEPTH];
    logic [INSTR_W-1:0] mem_instr [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic push;
    logic pop;

    // Ready looks only at the registered count, so a pop cannot free a slot
    // for a push in the same cycle.
    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_pc    = out_valid ? mem_pc[rd_ptr_q]    : '0;
    assign out_instr = out_valid ? mem_instr[rd_ptr_q] : '0;
    assign count     = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is never cleared; count alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush && !reset) begin
            mem_pc[wr_ptr_q]    <= in_pc;
            mem_instr[wr_ptr_q] <= in_instr;
        end
    end

endmodule
